// File: rtl/ucie_ctl_rx_buf_sched_if.sv
// Bundle of RX buffer scheduler signals: RX FSM/datapath write side, consumer read
// side and status. master = RX FSM / datapath / consumers, slave = the scheduler.
// Credit signals are present only when UCIE_CTL_RX_CREDIT_EN is defined.
interface ucie_ctl_rx_buf_sched_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               i_buffer_enable;
  logic               i_wr_valid;
  logic [DATA_W-1:0]  i_wr_data;
  logic [NUM_REQ-1:0] i_rd_req;
  logic [NUM_REQ-1:0] o_rd_grant;
  logic               o_rd_valid;
  logic [DATA_W-1:0]  o_rd_data;
  logic [CW-1:0]      o_count;
  logic               o_full;
  logic               o_empty;
  logic               o_overflow_detected;
`ifdef UCIE_CTL_RX_CREDIT_EN
  logic               o_credit_return;
  logic [CW-1:0]      o_credits_avail;

  modport master (
    output i_buffer_enable, i_wr_valid, i_wr_data, i_rd_req,
    input  o_rd_grant, o_rd_valid, o_rd_data, o_count, o_full, o_empty,
           o_overflow_detected, o_credit_return, o_credits_avail
  );
  modport slave (
    input  i_buffer_enable, i_wr_valid, i_wr_data, i_rd_req,
    output o_rd_grant, o_rd_valid, o_rd_data, o_count, o_full, o_empty,
           o_overflow_detected, o_credit_return, o_credits_avail
  );
`else
  modport master (
    output i_buffer_enable, i_wr_valid, i_wr_data, i_rd_req,
    input  o_rd_grant, o_rd_valid, o_rd_data, o_count, o_full, o_empty,
           o_overflow_detected
  );
  modport slave (
    input  i_buffer_enable, i_wr_valid, i_wr_data, i_rd_req,
    output o_rd_grant, o_rd_valid, o_rd_data, o_count, o_full, o_empty,
           o_overflow_detected
  );
`endif
endinterface

// File: rtl/ucie_ctl_rx_buf_sched.sv
// UCIe controller RX buffer scheduler: DEPTH-entry flit FIFO written by the RX
// datapath while the link is ACTIVE, read port shared round-robin among NUM_REQ
// consumers, overflow pulse on dropped writes, flush when the link leaves ACTIVE.
// Optional credit outputs are enabled by defining UCIE_CTL_RX_CREDIT_EN.
module ucie_ctl_rx_buf_sched #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_REQ = 4
) (
  input logic                    i_clk,
  input logic                    i_rst,
  ucie_ctl_rx_buf_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NUM_REQ);
  localparam int IW = RW + 1;

  typedef enum logic [1:0] {IDLE, SERVE, FLUSH} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;
  logic [RW-1:0]      rr_ptr;
  logic [RW-1:0]      rr_next;
  logic [RW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      idx;
  logic               found;
  logic               en_d;
  logic               full_now;
  logic               flush_go;
  logic               do_pop;
  logic               push;
  logic               drop;

  assign bus.o_count = count;

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'(rr_ptr) + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!found && bus.i_rd_req[idx[RW-1:0]]) begin
        found   = 1'b1;
        win_idx = idx[RW-1:0];
      end
    end
    win_oh  = NUM_REQ'(1) << win_idx;
    rr_next = (win_idx == RW'(NUM_REQ - 1)) ? '0 : win_idx + RW'(1);
  end

  // Per-cycle push/pop/flush decisions and next occupancy.
  always_comb begin
    full_now = (count == CW'(DEPTH));
    // In SERVE enable was high last cycle, so a low enable is always a falling edge.
    flush_go = ((state == IDLE) && en_d && !bus.i_buffer_enable) ||
               ((state == SERVE) && !bus.i_buffer_enable);
    // A pop launched here is presented (registered) next cycle, i.e. in SERVE.
    do_pop   = (state != FLUSH) && bus.i_buffer_enable && (|bus.i_rd_req) &&
               (count != '0);
    // A same-cycle pop frees the slot, so a write at full is still accepted.
    push     = bus.i_buffer_enable && bus.i_wr_valid && (!full_now || do_pop);
    drop     = bus.i_buffer_enable && bus.i_wr_valid && full_now && !do_pop;
    count_next = count;
    if (flush_go)              count_next = '0;
    else if (push && !do_pop)  count_next = count + CW'(1);
    else if (do_pop && !push)  count_next = count - CW'(1);
  end

  // Flit storage, write port only; no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_wr_data;
  end

  // Scheduler FSM with pointers, occupancy and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                   <= IDLE;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      rr_ptr                  <= '0;
      en_d                    <= 1'b0;
      bus.o_rd_grant          <= '0;
      bus.o_rd_valid          <= 1'b0;
      bus.o_rd_data           <= '0;
      bus.o_full              <= 1'b0;
      bus.o_empty             <= 1'b1;
      bus.o_overflow_detected <= 1'b0;
`ifdef UCIE_CTL_RX_CREDIT_EN
      bus.o_credit_return     <= 1'b0;
      bus.o_credits_avail     <= CW'(DEPTH);
`endif
    end else begin
      en_d                    <= bus.i_buffer_enable;
      bus.o_overflow_detected <= drop;
      count                   <= count_next;
      bus.o_full              <= (count_next == CW'(DEPTH));
      bus.o_empty             <= (count_next == '0);
`ifdef UCIE_CTL_RX_CREDIT_EN
      bus.o_credit_return     <= do_pop;
      bus.o_credits_avail     <= CW'(DEPTH) - count_next;
`endif
      if (flush_go) begin
        // Contents discarded; arbitration fairness (rr_ptr) carries over.
        state          <= FLUSH;
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        bus.o_rd_grant <= '0;
        bus.o_rd_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop) begin
          // Read happens before this edge's write, so push+pop at full returns the old head.
          state          <= SERVE;
          rd_ptr         <= rd_ptr + PW'(1);
          rr_ptr         <= rr_next;
          bus.o_rd_grant <= win_oh;
          bus.o_rd_valid <= 1'b1;
          bus.o_rd_data  <= mem[rd_ptr];
        end else begin
          state          <= IDLE;
          bus.o_rd_grant <= '0;
          bus.o_rd_valid <= 1'b0;
        end
      end
    end
  end
endmodule
